// File: rtl/fake_rd_pkg.sv
// fake_rd_pkg: pattern modes, FSM states and parity helper for the fake RD source
package fake_rd_pkg;
  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_UPDN = 2'd1;
  localparam logic [1:0] MODE_ALT  = 2'd2;
  localparam logic [1:0] MODE_WALK = 2'd3;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
  function automatic logic word_parity(input logic [15:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction
endpackage

// File: rtl/fake_rd_gen_if.sv
// fake_rd_gen_if: control inputs and serial frame outputs of the fake RD source
interface fake_rd_gen_if #(parameter int NCHAN = 2, parameter int FRAME_CNT_W = 16);
  logic                   ENABLE;
  logic                   TRIGGER;
  logic [1:0]             MODE;
  logic                   ENABLE_XFR;
  logic [NCHAN-1:0]       SERIAL_OUT;
  logic                   FRAME_DONE;
  logic [FRAME_CNT_W-1:0] FRAME_COUNT;
  logic [1:0]             DBG;
  modport master (input ENABLE, TRIGGER, MODE, output ENABLE_XFR, SERIAL_OUT, FRAME_DONE, FRAME_COUNT, DBG);
  modport slave (output ENABLE, TRIGGER, MODE, input ENABLE_XFR, SERIAL_OUT, FRAME_DONE, FRAME_COUNT, DBG);
endinterface

// File: rtl/fake_rd_chan.sv
// fake_rd_chan: one channel's pattern register, shift-out mux and parity accumulator
module fake_rd_chan
  import fake_rd_pkg::*;
#(
  parameter int WORD_WIDTH = 12,
  parameter int ODD_PARITY = 1,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          active,
  input  logic          word_advance,
  input  logic [1:0]    mode,
  input  logic [2:0]    chan,
  input  logic [BW-1:0] bit_idx,
  output logic          serial,
  output logic          par_acc
);
  logic [WORD_WIDTH-1:0] pat_q, pat_d, alt_init, init, nxt, shifted;
  logic acc_q, acc_d, data_bit, par_slot;
  always_comb begin
    alt_init = '0;
    for (int i = 0; i < WORD_WIDTH; i++) alt_init[i] = ((WORD_WIDTH - 1 - i) % 2) == 0;
  end
  always_comb begin
    init = mode == MODE_UP ? WORD_WIDTH'(chan) : mode == MODE_ALT ? alt_init :
           mode == MODE_WALK ? WORD_WIDTH'(1) : '0;
    nxt = mode == MODE_UP ? pat_q + 1'b1 :
          mode == MODE_UPDN ? (chan[0] ? pat_q - 1'b1 : pat_q + 1'b1) :
          mode == MODE_ALT ? ~pat_q : {pat_q[WORD_WIDTH-2:0], pat_q[WORD_WIDTH-1]};
    shifted = pat_q << bit_idx;
    data_bit = shifted[WORD_WIDTH-1];
    par_slot = bit_idx == BW'(WORD_WIDTH);
    serial = par_slot ? word_parity(16'(pat_q), ODD_PARITY != 0) : data_bit;
    pat_d = load ? init : word_advance ? nxt : pat_q;
    acc_d = (load || word_advance) ? 1'b0 : (active && !par_slot) ? acc_q ^ data_bit : acc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q <= '0;
      acc_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      acc_q <= acc_d;
    end
  end
  assign par_acc = acc_q;
endmodule

// File: rtl/rd_synchronizer.sv
// rd_synchronizer: two-flop resynchroniser for asynchronous control inputs
module rd_synchronizer (
  input  logic clk,
  input  logic d,
  output logic q
);
  logic meta_q;
  always_ff @(posedge clk) begin
    meta_q <= d;
    q <= meta_q;
  end
endmodule

// File: rtl/fake_rd_gen.sv
// fake_rd_gen: NCHAN framed serial test-pattern streams with per-word parity
module fake_rd_gen
  import fake_rd_pkg::*;
#(
  parameter int NCHAN = 2,
  parameter int WORD_WIDTH = 12,
  parameter int MEM_SIZE = 2048,
  parameter int ODD_PARITY = 1,
  parameter int FRAME_CNT_W = 16
) (
  input logic LOCAL_CLK,
  input logic LOCAL_RSTN,
  fake_rd_gen_if.master bus
);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam int WW = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1;
  state_e state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WW-1:0] word_q, word_d;
  logic [FRAME_CNT_W-1:0] count_q, count_d;
  logic [1:0] mode_q, mode_d, chan_mode;
  logic trig_prev_q, trig_prev_d, l_en, l_trig, load, adv, last_bit, last_word, xfr;
  logic [NCHAN-1:0] ser, acc;
  logic unused_acc;
  rd_synchronizer u_sync_en (.clk(LOCAL_CLK), .d(bus.ENABLE), .q(l_en));
  rd_synchronizer u_sync_trig (.clk(LOCAL_CLK), .d(bus.TRIGGER), .q(l_trig));
  assign last_bit = bit_q == BW'(WORD_WIDTH);
  assign last_word = word_q == WW'(MEM_SIZE - 1);
  assign xfr = state_q == SEND;
  assign chan_mode = load ? bus.MODE : mode_q;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    word_d = word_q;
    count_d = count_q;
    mode_d = mode_q;
    trig_prev_d = l_trig;
    load = 1'b0;
    adv = 1'b0;
    case (state_q)
      IDLE: if (l_trig && !trig_prev_q && l_en) begin
        state_d = SEND;
        mode_d = bus.MODE;
        load = 1'b1;
      end
      SEND: begin
        adv = last_bit;
        bit_d = last_bit ? '0 : bit_q + 1'b1;
        if (last_bit) word_d = last_word ? '0 : word_q + 1'b1;
        if (last_bit && last_word) begin
          state_d = DONE;
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // losing enable abandons the frame without counting it
    if (!l_en) begin
      state_d = IDLE;
      bit_d = '0;
      word_d = '0;
      count_d = count_q;
    end
  end
  always_ff @(posedge LOCAL_CLK) begin
    if (!LOCAL_RSTN) begin
      state_q <= IDLE;
      bit_q <= '0;
      word_q <= '0;
      count_q <= '0;
      mode_q <= MODE_UP;
      trig_prev_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      word_q <= word_d;
      count_q <= count_d;
      mode_q <= mode_d;
      trig_prev_q <= trig_prev_d;
    end
  end
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    fake_rd_chan #(.WORD_WIDTH(WORD_WIDTH), .ODD_PARITY(ODD_PARITY), .BW(BW)) u_chan (
      .clk(LOCAL_CLK), .rst_n(LOCAL_RSTN), .load(load), .active(xfr), .word_advance(adv),
      .mode(chan_mode), .chan(3'(c)), .bit_idx(bit_q), .serial(ser[c]), .par_acc(acc[c])
    );
  end
  assign unused_acc = ^acc;
  assign bus.ENABLE_XFR = xfr;
  assign bus.SERIAL_OUT = ser & {NCHAN{xfr}};
  assign bus.FRAME_DONE = state_q == DONE;
  assign bus.FRAME_COUNT = count_q;
  assign bus.DBG = {acc[NCHAN-1], bit_q[BW-1]};
endmodule

// File: doc/fake_rd_gen.md
Name: fake_rd_gen

Overview:
Parametrised successor to the fake radio-detector (RD) data source. It produces NCHAN parallel serial test streams with a selectable data pattern and a per-word parity bit. Each stream is framed by ENABLE_XFR and contains MEM_SIZE words of WORD_WIDTH bits. It sits on the RD side of the RD/UUB link and drives the production rd_interface receiver on the bench and in hardware loopback.

Parameters:
NCHAN, 2, number of serial data channels (1..8)
WORD_WIDTH, 12, data bits per word, sent MSB first (4..16)
MEM_SIZE, 2048, words per frame per channel (1..65535)
ODD_PARITY, 1, 1 = parity bit makes data+parity odd; 0 = even
FRAME_CNT_W, 16, width of FRAME_COUNT

Ports:
LOCAL_CLK  in  1  single clock; all logic on its rising edge
LOCAL_RSTN  in  1  synchronous active-low reset
ENABLE  in  1  asynchronous enable; resynchronised internally
TRIGGER  in  1  asynchronous trigger; resynchronised internally, rising edge starts a frame
MODE  in  2  pattern select; sampled when a frame starts
ENABLE_XFR  out  1  high for exactly the duration of a frame
SERIAL_OUT  out  NCHAN  serial data, bit c = channel c
FRAME_DONE  out  1  one-cycle pulse in the cycle after the last parity bit
FRAME_COUNT  out  FRAME_CNT_W  number of completed frames; wraps; aborted frames are not counted
DBG  out  2  {parity accumulator of channel NCHAN-1, bit-counter MSB}

Behaviour:
- Reset (LOCAL_RSTN=0 at a clock edge):
  - ENABLE_XFR, SERIAL_OUT, FRAME_DONE, FRAME_COUNT, DBG and all counters/patterns go to 0; state goes to IDLE.
  - The trigger edge-detect register resets to 1, so a TRIGGER already high at reset release does not start a frame.
- ENABLE and TRIGGER each pass through rd_synchronizer (2 flops, no reset), giving L_EN and L_TRIG.
- States:
  - IDLE: ENABLE_XFR=0, SERIAL_OUT=0. A rising edge of L_TRIG (L_TRIG=1, prev=0) with L_EN=1 moves to SEND, latches MODE and loads the patterns. ENABLE_XFR=1 and the first data bit appear in the next cycle.
  - SEND: each word takes WORD_WIDTH+1 cycles: data bits MSB first, then the parity bit. The bit counter runs 0..WORD_WIDTH; the word counter runs 0..MEM_SIZE-1. After the parity bit of word MEM_SIZE-1 the state moves to DONE.
  - DONE (1 cycle): ENABLE_XFR=0, SERIAL_OUT=0, FRAME_DONE=1, FRAME_COUNT incremented. Then IDLE.
- ENABLE_XFR is high for exactly MEM_SIZE*(WORD_WIDTH+1) consecutive cycles.
- Parity bit = XOR(data word) ^ ODD_PARITY.
- Patterns for channel c, each WORD_WIDTH bits, mod 2^WORD_WIDTH:
  - MODE 0: up-counter starting at c.
  - MODE 1 (legacy): even channels count up from 0, odd channels count down from 0 (word 1 = all ones).
  - MODE 2: alternating 1010…, inverted on every word.
  - MODE 3: walking one starting at bit 0, rotating left one bit per word.
- Pattern wrap is natural binary wrap, with no gap inserted.
- MODE changes during SEND are ignored until the next frame.
- TRIGGER edges during SEND or DONE are ignored; they are not queued.
- TRIGGER held high across a frame does not retrigger; a new rising edge is required.
- L_EN falling in any state: abort to IDLE on the next edge. ENABLE_XFR=0, SERIAL_OUT=0, no FRAME_DONE, FRAME_COUNT unchanged.
- L_EN rising while L_TRIG is already high does not start a frame.
- Reset mid-frame behaves like abort, and additionally clears FRAME_COUNT.

Decomposition:
- Package fake_rd_pkg:
  - MODE constants MODE_UP, MODE_UPDN, MODE_ALT, MODE_WALK.
  - State encoding IDLE/SEND/DONE.
  - Function word_parity(word, odd).
- Sub-module fake_rd_chan (instantiated NCHAN times via generate):
  - Holds the per-channel pattern register, shift-out mux and parity accumulator.
  - Inputs: load, mode, channel index, bit index, word_advance.
  - Outputs: serial bit, parity accumulator.
- Top level holds the FSM, counters, synchronizers (existing rd_synchronizer) and edge detect.

Test Plan:
1. Defaults, MODE=1, ENABLE=1, one TRIGGER pulse -> ENABLE_XFR high for 26624 cycles. ch0 words 0,1,2…; ch1 words 0,0xFFF,0xFFE…. Every parity bit gives odd total. FRAME_DONE pulses once and FRAME_COUNT=1.
2. NCHAN=4, WORD_WIDTH=8, MEM_SIZE=300, MODE=0 -> ch3 starts at 3 and wraps 0xFF→0x00 at word 253. ENABLE_XFR width = 2700 cycles.
3. MODE=3, WORD_WIDTH=12, ODD_PARITY=0 -> words 0x001,0x002,…,0x800,0x001. Every parity bit = 1 (even parity).
4. ENABLE dropped at word 100 -> ENABLE_XFR and SERIAL_OUT go to 0 within 3 cycles of ENABLE falling. No FRAME_DONE, FRAME_COUNT unchanged. The next TRIGGER edge restarts from word 0.
5. TRIGGER held high through reset release and through the enable rising -> no frame. TRIGGER edges toggled during SEND -> exactly one frame.
6. LOCAL_RSTN=0 mid-frame for one cycle -> all outputs 0 on the next edge. FRAME_COUNT=0 and the FSM is in IDLE.
